// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage between fetch and execute.
//
// Holds the IF/ID register, the register file and its writeback port, immediate
// generation, control decode and load-use hazard detection. It also holds the
// ID/EX output register.
//
// Ports
//   clk, reset (async, active-low)
//   fetch side    : if_valid, if_instr, if_pc -> stall_fetch (combinational hold request)
//   execute side  : flush (kill in-flight work), id_* (registered ID/EX contents)
//   writeback     : wb_we, wb_rd, wb_data (write-first bypass into operand read)
module decode_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RA_W = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall_fetch,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_rs1_data,
    output logic [XLEN-1:0] id_rs2_data,
    output logic [XLEN-1:0] id_imm,
    output logic [RA_W-1:0] id_rs1,
    output logic [RA_W-1:0] id_rs2,
    output logic [RA_W-1:0] id_rd,
    output logic [2:0]      id_funct3,
    output logic            id_funct7b5,
    output logic [6:0]      id_opcode,
    output logic            id_reg_write,
    output logic            id_mem_read,
    output logic            id_mem_write,
    output logic            id_alu_src,
    output logic            id_branch,
    output logic            id_jump,
    output logic            id_illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Immediate formats assume a 32-bit datapath; every format sign-extends from instr[31].
    function automatic logic signed [XLEN-1:0] gen_imm(input logic [31:0] ins);
        logic signed [XLEN-1:0] imm;
        case (ins[6:0])
            OP_LOAD, OP_IMM, OP_JALR: imm = {{20{ins[31]}}, ins[31:20]};
            OP_STORE:                 imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OP_BRANCH:                imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm = {ins[31:12], 12'b0};
            OP_JAL:                   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:                  imm = '0;
        endcase
        return imm;
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_JALR) || (op == OP_BRANCH) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_IMM) || (op == OP_OP);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_STORE) || (op == OP_OP);
    endfunction

    logic                   vld_p0;
    logic [31:0]            instr_p0;
    logic [XLEN-1:0]        pc_p0;
    logic [XLEN-1:0]        regs [NREG];

    logic [6:0]             opcode_p0;
    logic [RA_W-1:0]        rs1_p0, rs2_p0, rd_p0;
    logic signed [XLEN-1:0] imm_p0;
    logic [XLEN-1:0]        rs1_data_p0, rs2_data_p0;
    logic                   reg_write_p0, mem_read_p0, mem_write_p0;
    logic                   alu_src_p0, branch_p0, jump_p0, illegal_p0;
    logic                   hz;
    logic                   bubble;

    // ---- IF/ID stage (p0) ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            vld_p0 <= 1'b0;
        else if (flush)
            vld_p0 <= 1'b0;
        else if (!hz)
            vld_p0 <= if_valid;
    end

    always_ff @(posedge clk) begin
        if (!hz) begin
            instr_p0 <= if_instr;
            pc_p0    <= if_pc;
        end
    end

    // ---- Decode (combinational on IF/ID) ----
    assign opcode_p0 = instr_p0[6:0];
    assign rs1_p0    = instr_p0[19:15];
    assign rs2_p0    = instr_p0[24:20];
    assign rd_p0     = instr_p0[11:7];
    assign imm_p0    = gen_imm(instr_p0);

    always_comb begin
        reg_write_p0 = 1'b0;
        mem_read_p0  = 1'b0;
        mem_write_p0 = 1'b0;
        alu_src_p0   = 1'b0;
        branch_p0    = 1'b0;
        jump_p0      = 1'b0;
        illegal_p0   = 1'b0;
        case (opcode_p0)
            OP_LUI, OP_AUIPC, OP_IMM: begin
                reg_write_p0 = 1'b1;
                alu_src_p0   = 1'b1;
            end
            OP_LOAD: begin
                reg_write_p0 = 1'b1;
                mem_read_p0  = 1'b1;
                alu_src_p0   = 1'b1;
            end
            OP_STORE: begin
                mem_write_p0 = 1'b1;
                alu_src_p0   = 1'b1;
            end
            OP_OP:     reg_write_p0 = 1'b1;
            OP_BRANCH: branch_p0    = 1'b1;
            OP_JAL, OP_JALR: begin
                reg_write_p0 = 1'b1;
                alu_src_p0   = 1'b1;
                jump_p0      = 1'b1;
            end
            default:   illegal_p0   = 1'b1;
        endcase
    end

    // Write-first read: a same-cycle writeback to the addressed register wins over the array.
    always_comb begin
        if (rs1_p0 == '0)
            rs1_data_p0 = '0;
        else if (wb_we && (wb_rd == rs1_p0))
            rs1_data_p0 = wb_data;
        else
            rs1_data_p0 = regs[rs1_p0];

        if (rs2_p0 == '0)
            rs2_data_p0 = '0;
        else if (wb_we && (wb_rd == rs2_p0))
            rs2_data_p0 = wb_data;
        else
            rs2_data_p0 = regs[rs2_p0];
    end

    // A load in ID/EX whose result the IF/ID instruction needs costs one bubble.
    // The bubble clears id_valid, so hz drops on the following cycle by construction.
    assign hz = id_valid && id_mem_read && (id_rd != '0) && vld_p0 &&
                ((uses_rs1(opcode_p0) && (rs1_p0 == id_rd)) ||
                 (uses_rs2(opcode_p0) && (rs2_p0 == id_rd)));

    assign stall_fetch = hz && !flush;
    assign bubble      = flush || hz || !vld_p0;

    // ---- Register file ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else if (wb_we && (wb_rd != '0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // ---- ID/EX stage (p1) ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid     <= 1'b0;
            id_pc        <= '0;
            id_rs1_data  <= '0;
            id_rs2_data  <= '0;
            id_imm       <= '0;
            id_rs1       <= '0;
            id_rs2       <= '0;
            id_rd        <= '0;
            id_funct3    <= '0;
            id_funct7b5  <= 1'b0;
            id_opcode    <= '0;
            id_reg_write <= 1'b0;
            id_mem_read  <= 1'b0;
            id_mem_write <= 1'b0;
            id_alu_src   <= 1'b0;
            id_branch    <= 1'b0;
            id_jump      <= 1'b0;
            id_illegal   <= 1'b0;
        end else begin
            id_valid     <= !bubble;
            id_pc        <= pc_p0;
            id_rs1_data  <= rs1_data_p0;
            id_rs2_data  <= rs2_data_p0;
            id_imm       <= imm_p0;
            id_rs1       <= rs1_p0;
            id_rs2       <= rs2_p0;
            id_rd        <= rd_p0;
            id_funct3    <= instr_p0[14:12];
            id_funct7b5  <= instr_p0[30];
            id_opcode    <= opcode_p0;
            id_reg_write <= reg_write_p0 && !bubble;
            id_mem_read  <= mem_read_p0  && !bubble;
            id_mem_write <= mem_write_p0 && !bubble;
            id_alu_src   <= alu_src_p0   && !bubble;
            id_branch    <= branch_p0    && !bubble;
            id_jump      <= jump_p0      && !bubble;
            id_illegal   <= illegal_p0   && !bubble;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage.
// A table of decoded instructions is streamed through the stage with expectations
// queued at issue and compared as id_valid results appear; hand-written sequences
// cover bypass, load-use stall, x0 writes, flush during stall and mid-stream reset.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_fetch;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;
    logic [6:0]  id_opcode;
    logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src;
    logic        id_branch, id_jump, id_illegal;
    logic [6:0]  ctrl;

    decode_stage dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_fetch(stall_fetch), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5), .id_opcode(id_opcode),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_branch(id_branch), .id_jump(id_jump), .id_illegal(id_illegal)
    );

    always #5 clk = ~clk;

    // {reg_write, mem_read, mem_write, alu_src, branch, jump, illegal}
    assign ctrl = {id_reg_write, id_mem_read, id_mem_write, id_alu_src,
                   id_branch, id_jump, id_illegal};

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [6:0]  ctrl;
        bit          chk_imm;
    } vec_t;

    vec_t tbl [11];
    vec_t q [$];
    bit   sb_on;
    int   n_chk;
    int   n_fail;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; scoreboard compares when enabled.
    task automatic step();
        vec_t e;
        @(posedge clk);
        #1;
        if (sb_on && id_valid) begin
            if (q.size() == 0) begin
                chk("sb_pending", q.size(), 1);
            end else begin
                e = q.pop_front();
                chk("sb_pc", id_pc, e.pc);
                chk("sb_rd", {27'b0, id_rd}, {27'b0, e.rd});
                chk("sb_rs1", {27'b0, id_rs1}, {27'b0, e.rs1});
                chk("sb_ctrl", {25'b0, ctrl}, {25'b0, e.ctrl});
                chk("sb_opcode", {25'b0, id_opcode}, {25'b0, e.instr[6:0]});
                chk("sb_rs1_data", id_rs1_data, 32'h0);
                if (e.chk_imm)
                    chk("sb_imm", id_imm, e.imm);
            end
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; sb_on = 1'b0;
        tbl[0]  = '{32'h3e800093, 0, 32'd1000,     5'd1,  5'd0,  7'b1001000, 1'b1}; // addi x1,x0,1000
        tbl[1]  = '{32'hffc12283, 0, 32'hfffffffc, 5'd5,  5'd2,  7'b1101000, 1'b1}; // lw x5,-4(x2)
        tbl[2]  = '{32'h0061a423, 0, 32'd8,        5'd8,  5'd3,  7'b0011000, 1'b1}; // sw x6,8(x3)
        tbl[3]  = '{32'hfe208ce3, 0, 32'hfffffff8, 5'd25, 5'd1,  7'b0000100, 1'b1}; // beq x1,x2,-8
        tbl[4]  = '{32'h123453b7, 0, 32'h12345000, 5'd7,  5'd8,  7'b1001000, 1'b1}; // lui x7,0x12345
        tbl[5]  = '{32'hfffff417, 0, 32'hfffff000, 5'd8,  5'd31, 7'b1001000, 1'b1}; // auipc x8,0xfffff
        tbl[6]  = '{32'hffdff0ef, 0, 32'hfffffffc, 5'd1,  5'd31, 7'b1001010, 1'b1}; // jal x1,-4
        tbl[7]  = '{32'h00008067, 0, 32'h0,        5'd0,  5'd1,  7'b1001010, 1'b1}; // jalr x0,0(x1)
        tbl[8]  = '{32'hffffffff, 0, 32'h0,        5'd31, 5'd31, 7'b0000001, 1'b0}; // unknown opcode
        tbl[9]  = '{32'h002081b3, 0, 32'h0,        5'd3,  5'd1,  7'b1000000, 1'b1}; // add x3,x1,x2
        tbl[10] = '{32'hfff0e493, 0, 32'hffffffff, 5'd9,  5'd1,  7'b1001000, 1'b1}; // ori x9,x1,-1

        reset = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_stall", {31'b0, stall_fetch}, 32'h0);
        chk("rst_ctrl", {25'b0, ctrl}, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        reset = 1'b1;

        // Table stream, one instruction per cycle.
        sb_on = 1'b1;
        for (int i = 0; i < 11; i++) begin
            vec_t e;
            if_valid = 1'b1;
            if_instr = tbl[i].instr;
            if_pc    = 32'h100 + 32'(4 * i);
            e        = tbl[i];
            e.pc     = if_pc;
            q.push_back(e);
            step();
        end
        if_valid = 1'b0;
        repeat (3) step();
        chk("sb_drain", q.size(), 0);
        sb_on = 1'b0;

        // Writeback bypass in the decode cycle, then the stored value.
        if_valid = 1'b1; if_instr = 32'h00108133;            // add x2,x1,x1
        step();
        if_valid = 1'b0; wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd1000;
        step();
        wb_we = 1'b0;
        chk("byp_valid", {31'b0, id_valid}, 32'h1);
        chk("byp_rs1_data", id_rs1_data, 32'd1000);
        chk("byp_rs2_data", id_rs2_data, 32'd1000);
        chk("byp_rd", {27'b0, id_rd}, 32'd2);
        chk("byp_alu_src", {31'b0, id_alu_src}, 32'h0);
        if_valid = 1'b1; if_instr = 32'h001081b3;            // add x3,x1,x1
        step();
        if_valid = 1'b0;
        step();
        chk("rf_x1", id_rs1_data, 32'd1000);

        // Load-use: one stall cycle, one bubble, then the consumer.
        if_valid = 1'b1; if_instr = 32'h00002283;            // lw x5,0(x0)
        step();
        if_instr = 32'h00528333;                             // add x6,x5,x5
        step();
        chk("lu_stall", {31'b0, stall_fetch}, 32'h1);
        chk("lu_load_mr", {31'b0, id_mem_read}, 32'h1);
        step();
        chk("lu_stall_once", {31'b0, stall_fetch}, 32'h0);
        chk("lu_bubble", {31'b0, id_valid}, 32'h0);
        chk("lu_bubble_ctrl", {25'b0, ctrl}, 32'h0);
        if_valid = 1'b0;
        step();
        chk("lu_add_valid", {31'b0, id_valid}, 32'h1);
        chk("lu_add_rs1", {27'b0, id_rs1}, 32'd5);
        chk("lu_add_rs2", {27'b0, id_rs2}, 32'd5);
        chk("lu_add_rd", {27'b0, id_rd}, 32'd6);

        // Load followed by an independent instruction: no stall.
        if_valid = 1'b1; if_instr = 32'h00002283;            // lw x5,0(x0)
        step();
        if_instr = 32'h00000333;                             // add x6,x0,x0
        step();
        chk("nolu_stall", {31'b0, stall_fetch}, 32'h0);
        if_valid = 1'b0;
        step();
        chk("nolu_valid", {31'b0, id_valid}, 32'h1);
        chk("nolu_rd", {27'b0, id_rd}, 32'd6);

        // Writes to x0 are dropped, both stored and bypassed.
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hdeadbeef;
        step();
        if_valid = 1'b1; if_instr = 32'h000001b3;            // add x3,x0,x0
        step();
        if_valid = 1'b0;
        step();
        wb_we = 1'b0;
        chk("x0_valid", {31'b0, id_valid}, 32'h1);
        chk("x0_rs1_data", id_rs1_data, 32'h0);
        chk("x0_rs2_data", id_rs2_data, 32'h0);

        // Flush during a load-use stall wins.
        if_valid = 1'b1; if_instr = 32'h00002283;            // lw x5,0(x0)
        step();
        if_instr = 32'h00528333;                             // add x6,x5,x5
        step();
        chk("fl_stall_before", {31'b0, stall_fetch}, 32'h1);
        flush = 1'b1;
        #1;
        chk("fl_stall_masked", {31'b0, stall_fetch}, 32'h0);
        step();
        flush = 1'b0; if_valid = 1'b0;
        chk("fl_bubble", {31'b0, id_valid}, 32'h0);
        chk("fl_bubble_ctrl", {25'b0, ctrl}, 32'h0);
        step();
        chk("fl_ifid_empty", {31'b0, id_valid}, 32'h0);

        // Mid-stream reset clears pipeline and register file immediately.
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd55;
        step();
        wb_we = 1'b0;
        if_valid = 1'b1; if_instr = 32'h001081b3;            // add x3,x1,x1
        step();
        if_valid = 1'b0;
        step();
        chk("pre_rst_x1", id_rs1_data, 32'd55);
        chk("pre_rst_valid", {31'b0, id_valid}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", {31'b0, id_valid}, 32'h0);
        chk("arst_rd", {27'b0, id_rd}, 32'h0);
        chk("arst_data", id_rs1_data, 32'h0);
        chk("arst_ctrl", {25'b0, ctrl}, 32'h0);
        chk("arst_stall", {31'b0, stall_fetch}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        if_valid = 1'b1; if_instr = 32'h001081b3;            // add x3,x1,x1
        step();
        if_valid = 1'b0;
        step();
        chk("post_rst_valid", {31'b0, id_valid}, 32'h1);
        chk("post_rst_x1", id_rs1_data, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
